// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core: data widths, the canonical NOP and
// instruction source-register field positions.
package cpu_pkg;

   localparam int XLEN   = 32;
   localparam int REG_W  = 5;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   // sll $0,$0,0 encodes as all zeros
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

   function automatic logic [REG_W-1:0] rs_field(input logic [XLEN-1:0] inst);
      return inst[RS_MSB:RS_LSB];
   endfunction

   function automatic logic [REG_W-1:0] rt_field(input logic [XLEN-1:0] inst);
      return inst[RT_MSB:RT_LSB];
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the load in ID/EX writes a register
// that the instruction in IF/ID reads through either source field.
module hazard_detect
   import cpu_pkg::*;
(
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rt_i,
   input  logic [REG_W-1:0] ifid_rs_i,
   input  logic [REG_W-1:0] ifid_rt_i,
   input  logic             valid_i,
   output logic             stall_o
);

   // rt is compared even for instructions that do not read it; a spurious
   // one-cycle stall is harmless, a missed one is not
   always_comb begin
      stall_o = idex_memread_i & valid_i & (idex_rt_i != '0) &
                ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
   end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID register of the 5-stage MIPS core, with load-use stall.
// Optional stall/flush performance counters are enabled by IF_ID_PERF_CNT_EN.
module if_id_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [XLEN-1:0]  imem_addr_o,
   input  logic [XLEN-1:0]  imem_data_i,
   input  logic             redirect_i,
   input  logic [XLEN-1:0]  redirect_pc_i,
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rt_i,
   output logic [XLEN-1:0]  inst_o,
   output logic [XLEN-1:0]  pc_plus4_o,
   output logic             valid_o,
   output logic             stall_o,
`ifdef IF_ID_PERF_CNT_EN
   output logic [31:0]      stall_cnt_o,
   output logic [31:0]      flush_cnt_o,
`endif
   output logic             bubble_o
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next_seq;
   logic            stall;

   // Redirect targets are word aligned, so the low two bits are dropped
   wire unused_redirect_lsbs = ^redirect_pc_i[1:0];

   assign pc_next_seq = pc + 32'd4;
   assign imem_addr_o = pc;
   assign stall_o     = stall;
   assign bubble_o    = stall | redirect_i;

   hazard_detect u_hazard_detect (
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .ifid_rs_i      (rs_field(inst_o)),
      .ifid_rt_i      (rt_field(inst_o)),
      .valid_i        (valid_o),
      .stall_o        (stall)
   );

   // Redirect squashes everything, including an instruction that is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         inst_o     <= NOP_INST;
         pc_plus4_o <= '0;
         valid_o    <= 1'b0;
      end else if (redirect_i) begin
         pc         <= {redirect_pc_i[XLEN-1:2], 2'b00};
         inst_o     <= NOP_INST;
         pc_plus4_o <= '0;
         valid_o    <= 1'b0;
      end else if (!stall) begin
         pc         <= pc_next_seq;
         inst_o     <= imem_data_i;
         pc_plus4_o <= pc_next_seq;
         valid_o    <= 1'b1;
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   // A stall overridden by a redirect counts as a flush only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else if (redirect_i) begin
         flush_cnt_o <= flush_cnt_o + 32'd1;
      end else if (stall) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule
